// File: rtl/delay_arbiter.sv
// Round-robin scheduler that shares one external fixed-latency delay line between requesters A and B.
// Optional grant counters are enabled with the DLY_ARB_CNT_EN macro.
module delay_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic [WIDTH-1:0] dly_din,
    input  logic [WIDTH-1:0] dly_dout,
    output logic             a_out_valid,
    output logic [WIDTH-1:0] a_out_data,
    output logic             b_out_valid,
    output logic [WIDTH-1:0] b_out_data,
    output logic             busy,
    output logic             flush_done
`ifdef DLY_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0] a_grant_cnt,
    output logic [CNT_W-1:0] b_grant_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int DCNT_W = $clog2(DEPTH + 2);

    if (DEPTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("delay_arbiter: DEPTH and CNT_W must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic [DCNT_W-1:0] cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              a_rdy, b_rdy, accept;
    logic [WIDTH-1:0]  dly_din_q, dly_din_d;
    // Stage 0 sits beside dly_din; stage DEPTH lines up with dly_dout.
    logic [DEPTH:0]    tag_vld_q, tag_vld_d;
    logic [DEPTH:0]    tag_own_q, tag_own_d;
    logic              a_out_valid_q, a_out_valid_d;
    logic              b_out_valid_q, b_out_valid_d;
    logic [WIDTH-1:0]  a_out_data_q, a_out_data_d;
    logic [WIDTH-1:0]  b_out_data_q, b_out_data_d;

    // last_grant: 0 = A, 1 = B. A tie goes to whichever side was not granted last.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        if (state_q == S_RUN) begin
            if (a_valid && b_valid) begin
                a_rdy = last_grant_q;
                b_rdy = ~last_grant_q;
            end else begin
                a_rdy = a_valid;
                b_rdy = b_valid;
            end
        end
    end

    assign accept = a_rdy | b_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_DRAIN;
                    cnt_d   = DCNT_W'(DEPTH + 1);
                end else if (en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_DRAIN;
                    cnt_d   = DCNT_W'(DEPTH + 1);
                end else if (!en) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - DCNT_W'(1);
                if (cnt_q == DCNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d  = accept ? b_rdy : last_grant_q;
        dly_din_d     = a_rdy ? a_data : (b_rdy ? b_data : '0);
        tag_vld_d     = {tag_vld_q[DEPTH-1:0], accept};
        tag_own_d     = {tag_own_q[DEPTH-1:0], b_rdy};
        a_out_valid_d = tag_vld_q[DEPTH] & ~tag_own_q[DEPTH];
        b_out_valid_d = tag_vld_q[DEPTH] & tag_own_q[DEPTH];
        a_out_data_d  = a_out_valid_d ? dly_dout : a_out_data_q;
        b_out_data_d  = b_out_valid_d ? dly_dout : b_out_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_grant_q  <= 1'b1;
            dly_din_q     <= '0;
            tag_vld_q     <= '0;
            tag_own_q     <= '0;
            a_out_valid_q <= 1'b0;
            b_out_valid_q <= 1'b0;
            a_out_data_q  <= '0;
            b_out_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            dly_din_q     <= dly_din_d;
            tag_vld_q     <= tag_vld_d;
            tag_own_q     <= tag_own_d;
            a_out_valid_q <= a_out_valid_d;
            b_out_valid_q <= b_out_valid_d;
            a_out_data_q  <= a_out_data_d;
            b_out_data_q  <= b_out_data_d;
        end
    end

    assign a_ready     = a_rdy;
    assign b_ready     = b_rdy;
    assign dly_din     = dly_din_q;
    assign a_out_valid = a_out_valid_q;
    assign b_out_valid = b_out_valid_q;
    assign a_out_data  = a_out_data_q;
    assign b_out_data  = b_out_data_q;
    assign busy        = |tag_vld_q;
    assign flush_done  = (state_q == S_DONE);

`ifdef DLY_ARB_CNT_EN
    logic [CNT_W-1:0] a_grant_cnt_q, a_grant_cnt_d;
    logic [CNT_W-1:0] b_grant_cnt_q, b_grant_cnt_d;

    // Saturating grant counters, cleared as the drain sequence completes.
    always_comb begin
        a_grant_cnt_d = a_grant_cnt_q;
        b_grant_cnt_d = b_grant_cnt_q;
        if (state_q == S_DONE) begin
            a_grant_cnt_d = '0;
            b_grant_cnt_d = '0;
        end else begin
            if (a_rdy && (a_grant_cnt_q != '1)) a_grant_cnt_d = a_grant_cnt_q + 1'b1;
            if (b_rdy && (b_grant_cnt_q != '1)) b_grant_cnt_d = b_grant_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_grant_cnt_q <= '0;
            b_grant_cnt_q <= '0;
        end else begin
            a_grant_cnt_q <= a_grant_cnt_d;
            b_grant_cnt_q <= b_grant_cnt_d;
        end
    end

    assign a_grant_cnt = a_grant_cnt_q;
    assign b_grant_cnt = b_grant_cnt_q;
`endif

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter with a behavioural delay-line model attached.
// Build with DLY_ARB_CNT_EN defined to also exercise the grant counters.
module tb_delay_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int LAT   = DEPTH + 2;

    logic             clk = 1'b0;
    logic             rst, en, flush;
    logic             a_valid, b_valid, a_ready, b_ready;
    logic [WIDTH-1:0] a_data, b_data, dly_din, dly_dout;
    logic             a_out_valid, b_out_valid, busy, flush_done;
    logic [WIDTH-1:0] a_out_data, b_out_data;
`ifdef DLY_ARB_CNT_EN
    logic [CNT_W-1:0] a_grant_cnt, b_grant_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic             own;
        logic [WIDTH-1:0] data;
        int               at;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .dly_din(dly_din), .dly_dout(dly_dout),
        .a_out_valid(a_out_valid), .a_out_data(a_out_data),
        .b_out_valid(b_out_valid), .b_out_data(b_out_data),
        .busy(busy), .flush_done(flush_done)
`ifdef DLY_ARB_CNT_EN
        , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
    );

    // External delay line: not touched by reset, starts full of 0xFF.
    logic [WIDTH-1:0] dl [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) dl[i] = 8'hFF;
    always @(posedge clk) begin
        dl[0] <= dly_din;
        for (int i = 1; i < DEPTH; i++) dl[i] <= dl[i-1];
    end
    assign dly_dout = dl[DEPTH-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && (a_out_valid || b_out_valid)) begin
            tests++;
            if (a_out_valid && b_out_valid) begin
                fails++;
                $display("FAIL both_out cyc=%0d actual=both valid required=one", cyc);
            end else if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out cyc=%0d a_v=%b b_v=%b a_d=%h b_d=%h required=no pulse",
                         cyc, a_out_valid, b_out_valid, a_out_data, b_out_data);
            end else begin
                exp_t e;
                logic             own;
                logic [WIDTH-1:0] d;
                e   = sbq.pop_front();
                own = b_out_valid;
                d   = own ? b_out_data : a_out_data;
                if (own !== e.own || d !== e.data || cyc != e.at) begin
                    fails++;
                    $display("FAIL out_match actual own=%b data=%h cyc=%0d required own=%b data=%h cyc=%0d",
                             own, d, cyc, e.own, e.data, e.at);
                end
            end
        end
    end

    task automatic step(input logic av, input logic [WIDTH-1:0] ad, input logic bv,
                        input logic [WIDTH-1:0] bd, input logic fl, input logic ear, input logic ebr);
        exp_t e;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; flush = fl;
        @(negedge clk);
        chk("a_ready", a_ready, ear);
        chk("b_ready", b_ready, ebr);
        if (ear) begin e.own = 1'b0; e.data = ad; e.at = cyc + LAT; sbq.push_back(e); end
        if (ebr) begin e.own = 1'b1; e.data = bd; e.at = cyc + LAT; sbq.push_back(e); end
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            idle(1);
            n++;
        end
        chk("sb_drained", sbq.size(), 0);
        idle(2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_b_ready"}, b_ready, 0);
        chk({tag, "_dly_din"}, dly_din, 0);
        chk({tag, "_a_out_valid"}, a_out_valid, 0);
        chk({tag, "_a_out_data"}, a_out_data, 0);
        chk({tag, "_b_out_valid"}, b_out_valid, 0);
        chk({tag, "_b_out_data"}, b_out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
    endtask

    task automatic do_reset();
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; en = 1'b0;
        rst = 1'b0;
        #1;
        chk_zero("rst");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        rst = 1'b0; en = 1'b0; flush = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        rst = 1'b1;

        // Stale 0xFF in the delay line must never surface.
        en = 1'b1;
        idle(LAT + 2);
        chk("idle_busy", busy, 0);

        step(1'b1, 8'h11, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        drain_wait();

        // Fresh reset: first tie goes to A, then strict alternation.
        do_reset();
        en = 1'b1;
        step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hA1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hA2, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
        drain_wait();

        // Dropping en returns to IDLE where nothing is granted.
        en = 1'b0;
        idle(1);
        step(1'b1, 8'h55, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        idle(1);

        // Flush with three bytes in flight.
        step(1'b1, 8'hC1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hC2, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        fc = cyc;
        step(1'b1, 8'hC3, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            a_valid = 1'b1; a_data = 8'hC4; flush = 1'b0;
            @(negedge clk);
            chk("drain_a_ready", a_ready, 0);
            chk("flush_done_timing", flush_done, (cyc == fc + LAT));
            if (k == 1) chk("busy_in_flight", busy, 1);
            if (k == LAT) chk("busy_at_done", busy, 0);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        drain_wait();

        // Asynchronous reset in the middle of a stream.
        step(1'b1, 8'hD1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hD2, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        a_valid = 1'b1; a_data = 8'hD3;
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        sbq.delete();
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(LAT + 4);
        chk("post_rst_busy", busy, 0);

`ifdef DLY_ARB_CNT_EN
        do_reset();
        en = 1'b1;
        idle(1);
        for (int i = 1; i <= 20; i++) step(1'b1, WIDTH'(i), 1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("a_grant_cnt_sat", a_grant_cnt, 15);
        chk("b_grant_cnt_zero", b_grant_cnt, 0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(LAT + 1);
        chk("a_grant_cnt_clr", a_grant_cnt, 0);
        chk("b_grant_cnt_clr", b_grant_cnt, 0);
        drain_wait();
`endif

        drain_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
